line_data_memory: RTL
=====================

// Module: line_data_memory
// PURPOSE
//   Off-chip data memory model behind the L1 data cache; consumes the cache's
//   mem_enable/mem_write/mem_addr/mem_data request and returns one 256-bit line.
//   Fixed multi-cycle latency, one outstanding request, single-cycle ack pulse.
//   Drives the CPU-level mem_data_i/mem_ack_i inputs in the testbench top.
// PARAMETERS
//   LINE_W   256  line width in bits (32 bytes)
//   ADDR_W   32   byte-address width
//   DEPTH    512  number of lines in storage array (power of two)
//   LATENCY  10   cycles from request acceptance to ack (>=2)
// PORTS
//   clk_i     in   1       clock, rising edge
//   rst_i     in   1       asynchronous, active-high reset
//   addr_i    in   ADDR_W  byte address of request; bits [4:0] ignored
//   data_i    in   LINE_W  write line data
//   enable_i  in   1       request valid
//   write_i   in   1       1 = write line, 0 = read line
//   ack_o     out  1       one-cycle completion pulse
//   data_o    out  LINE_W  read line; valid while ack_o=1
//   busy_o    out  1       request in flight (state != IDLE)
// BEHAVIOUR
//   Reset (async, any time): state=IDLE, cnt=0, ack_o=0, data_o=0, busy_o=0.
//     Array contents NOT reset. Request in flight is aborted; a pending write
//     that has not reached its commit edge is not performed.
//   Line index = addr[4+log2(DEPTH):5]; upper address bits ignored (aliasing).
//   FSM states IDLE, WAIT, ACK:
//     IDLE: enable_i=1 at edge N -> latch addr, data, write; cnt=0; go WAIT.
//     WAIT: cnt increments each edge; when cnt==LATENCY-2 at an edge -> ACK.
//     ACK : ack_o=1 for exactly this cycle; next edge -> IDLE.
//   Timing: request accepted at edge N, ack_o high in cycle after edge
//     N+LATENCY-1 (LATENCY edges from acceptance to ack falling).
//   Write commits to array at the edge entering ACK; read samples array at
//     that same edge into data_o. data_o holds its value outside ACK.
//   Inputs are ignored in WAIT and ACK; the latched copy is used. Dropping
//     enable_i mid-WAIT does not cancel the request.
//   enable_i still high in the ACK cycle is not a new request; if still high
//     in the following IDLE cycle, it is accepted (back-to-back allowed).
//   busy_o = (state != IDLE); ack_o is registered, never combinational.
//   Read of a never-written line returns X in simulation; benches preload.
// TESTING
//   1 Write 0xA5..A5 line to addr 0x0000_0040, then read 0x0000_0040 ->
//     ack_o after exactly 10 cycles each; read data_o = 0xA5..A5.
//   2 Read addr 0x0000_005F -> same line as 0x40 (low 5 bits ignored).
//   3 Write line to index 0 via addr 0x0000_4000 (DEPTH=512 aliasing) ->
//     read of addr 0x0 returns that line.
//   4 Hold enable_i high across ack -> second request accepted in cycle
//     after ack; two acks exactly 11 cycles apart; busy_o low 1 cycle between.
//   5 Write issued, rst_i pulsed at cycle 5 -> ack_o, busy_o drop immediately
//     (async); no ack; later read shows old line contents unchanged.
//   6 enable_i dropped after acceptance, addr_i/data_i changed mid-WAIT ->
//     ack still at cycle 10; latched address/data used.

Source files
------------

// File: rtl/line_data_memory.sv
// Fixed-latency line memory model sitting behind the L1 data cache.
// One request in flight; completion is signalled by a registered one-cycle ack.
module line_data_memory #(
    parameter int LINE_W  = 256,
    parameter int ADDR_W  = 32,
    parameter int DEPTH   = 512,
    parameter int LATENCY = 10
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [LINE_W-1:0] data_i,
    input  logic              enable_i,
    input  logic              write_i,
    output logic              ack_o,
    output logic [LINE_W-1:0] data_o,
    output logic              busy_o
);
    // Handshake: enable_i acts as "valid" and !busy_o as "ready"; a request
    // transfers on the rising edge where both are high, and ack_o pulses once
    // for it LATENCY-1 edges later. Inputs are don't-care while busy_o is high.

    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = (LATENCY > 2) ? $clog2(LATENCY) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(LATENCY - 2);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_ACK  = 2'd2
    } state_t;

    state_t            state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [IDX_W-1:0]  idx_q;
    logic [LINE_W-1:0] wdata_q;
    logic              write_q;
    logic              ack_q;
    logic [LINE_W-1:0] rdata_q;
    logic [LINE_W-1:0] mem_q [DEPTH];

    logic commit;
    logic unused_addr_bits;

    // Only the line index is kept; offset and upper bits alias by design.
    assign unused_addr_bits = ^{addr_i[ADDR_W-1:IDX_W+5], addr_i[4:0]};
    assign commit = (state_q == S_WAIT) && (cnt_q == LAST_CNT);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            wdata_q <= '0;
            write_q <= 1'b0;
            ack_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    ack_q <= 1'b0;
                    if (enable_i) begin
                        idx_q   <= addr_i[IDX_W+4:5];
                        wdata_q <= data_i;
                        write_q <= write_i;
                        cnt_q   <= '0;
                        state_q <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (commit) begin
                        ack_q   <= 1'b1;
                        state_q <= S_ACK;
                        if (!write_q) begin
                            rdata_q <= mem_q[idx_q];
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                S_ACK: begin
                    ack_q   <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    ack_q   <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    // Storage is deliberately not reset; a reset before the commit edge
    // forces IDLE, so an aborted write never reaches the array.
    always_ff @(posedge clk_i) begin
        if (commit && write_q) begin
            mem_q[idx_q] <= wdata_q;
        end
    end

    assign ack_o  = ack_q;
    assign data_o = rdata_q;
    assign busy_o = (state_q != S_IDLE);

endmodule
